pipe_fwd: RTL



---
 rtl/pipe_fwd_if.sv | 34 +++
 rtl/pipe_fwd.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipe_fwd_if.sv
// rtl/pipe_fwd_if.sv - issue and result bundle of the forwarding pipeline
// Issue side : in_valid, func, rs1, rs2, rd, addr, wr_reg, wr_mem
//              (driven by the sequencer, no backpressure)
// Result side: out_valid, zout, zout_rd (driven by the pipeline)
// master = sequencer, slave = pipe_fwd
interface pipe_fwd_if #(
   parameter int DW   = 16,
   parameter int NREG = 16,
   parameter int AW   = 8
);
   localparam int RW = $clog2(NREG);

   logic          in_valid;
   logic [3:0]    func;
   logic [RW-1:0] rs1;
   logic [RW-1:0] rs2;
   logic [RW-1:0] rd;
   logic [AW-1:0] addr;
   logic          wr_reg;
   logic          wr_mem;
   logic          out_valid;
   logic [DW-1:0] zout;
   logic [RW-1:0] zout_rd;

   modport master (
      output in_valid, func, rs1, rs2, rd, addr, wr_reg, wr_mem,
      input  out_valid, zout, zout_rd
   );

   modport slave (
      input  in_valid, func, rs1, rs2, rd, addr, wr_reg, wr_mem,
      output out_valid, zout, zout_rd
   );
endinterface

// File: rtl/pipe_fwd.sv
// rtl/pipe_fwd.sv - 4-stage register/memory pipeline with full forwarding
// Ports: clk, rst_n (async, active-low)
//        bus       : pipe_fwd_if.slave issue/result bundle
//        dbg_raddr : debug register index  -> dbg_rdata (combinational)
//        dbg_maddr : debug memory address  -> dbg_mdata (combinational)
module pipe_fwd #(
   parameter int  DW   = 16,
   parameter int  NREG = 16,
   parameter int  AW   = 8,
   localparam int RW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   pipe_fwd_if.slave     bus,
   input  logic [RW-1:0] dbg_raddr,
   output logic [DW-1:0] dbg_rdata,
   input  logic [AW-1:0] dbg_maddr,
   output logic [DW-1:0] dbg_mdata
);
   logic [DW-1:0] regbank [NREG];
   logic [DW-1:0] membank [1 << AW];

   // S1: operands as read from the regbank at issue
   logic          v1, wr_reg1, wr_mem1;
   logic [DW-1:0] a1, b1;
   logic [RW-1:0] rs1_1, rs2_1, rd1;
   logic [3:0]    func1;
   logic [AW-1:0] addr1;

   // S2: computed result
   logic          v2, wr_reg2, wr_mem2;
   logic [RW-1:0] rd2;
   logic [AW-1:0] addr2;
   logic [DW-1:0] res2;

   // S3: visible result, pending memory write
   logic          v3, wr_reg3, wr_mem3;
   logic [RW-1:0] rd3;
   logic [AW-1:0] addr3;
   logic [DW-1:0] zout_r;

   logic [DW-1:0] a_f, b_f, m_f, res;

   // Forwarding: the S2 entry is younger than S3, so it wins. The S3 term
   // covers a regbank write landing on the very edge the consumer issued,
   // where the S1 latch captured the pre-write value.
   always_comb begin
      a_f = a1;
      b_f = b1;
      m_f = membank[addr1];
      if (v2 && wr_reg2 && rd2 == rs1_1)      a_f = res2;
      else if (v3 && wr_reg3 && rd3 == rs1_1) a_f = zout_r;
      if (v2 && wr_reg2 && rd2 == rs2_1)      b_f = res2;
      else if (v3 && wr_reg3 && rd3 == rs2_1) b_f = zout_r;
      if (v2 && wr_mem2 && addr2 == addr1)      m_f = res2;
      else if (v3 && wr_mem3 && addr3 == addr1) m_f = zout_r;
   end

   always_comb begin
      res = '0;
      case (func1)
         4'd0:  res = a_f + b_f;
         4'd1:  res = a_f - b_f;
         4'd2:  res = a_f * b_f;
         4'd3:  res = a_f;
         4'd4:  res = b_f;
         4'd5:  res = a_f & b_f;
         4'd6:  res = a_f | b_f;
         4'd7:  res = a_f ^ b_f;
         4'd8:  res = ~a_f;
         4'd9:  res = ~b_f;
         4'd10: res = a_f >> 1;
         4'd11: res = b_f << 1;
         4'd12: res = m_f;
         4'd13: res[AW-1:0] = addr1;
         default: res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0; wr_reg1 <= 1'b0; wr_mem1 <= 1'b0;
         a1 <= '0; b1 <= '0; rs1_1 <= '0; rs2_1 <= '0; rd1 <= '0;
         func1 <= '0; addr1 <= '0;
         v2 <= 1'b0; wr_reg2 <= 1'b0; wr_mem2 <= 1'b0;
         rd2 <= '0; addr2 <= '0; res2 <= '0;
         v3 <= 1'b0; wr_reg3 <= 1'b0; wr_mem3 <= 1'b0;
         rd3 <= '0; addr3 <= '0; zout_r <= '0;
         for (int i = 0; i < NREG; i++) regbank[i] <= '0;
      end else begin
         v1      <= bus.in_valid;
         a1      <= regbank[bus.rs1];
         b1      <= regbank[bus.rs2];
         rs1_1   <= bus.rs1;
         rs2_1   <= bus.rs2;
         rd1     <= bus.rd;
         func1   <= bus.func;
         addr1   <= bus.addr;
         wr_reg1 <= bus.wr_reg;
         wr_mem1 <= bus.wr_mem;

         v2      <= v1;
         wr_reg2 <= wr_reg1;
         wr_mem2 <= wr_mem1;
         rd2     <= rd1;
         addr2   <= addr1;
         res2    <= res;

         v3      <= v2;
         wr_reg3 <= wr_reg2;
         wr_mem3 <= wr_mem2;
         rd3     <= rd2;
         addr3   <= addr2;
         zout_r  <= res2;
         if (v2 && wr_reg2) regbank[rd2] <= res2;
      end
   end

   // Memory is not cleared by reset; v3 is, so no write escapes a reset.
   always_ff @(posedge clk) begin
      if (v3 && wr_mem3) membank[addr3] <= zout_r;
   end

   assign bus.out_valid = v3;
   assign bus.zout      = zout_r;
   assign bus.zout_rd   = rd3;
   assign dbg_rdata     = regbank[dbg_raddr];
   assign dbg_mdata     = membank[dbg_maddr];
endmodule
